// File: rtl/fp_types_pkg.sv
// Shared FP decode types: opcode/function constants, the decoded packet struct and
// the helper that says which FP source registers a packet actually reads.
package fp_types_pkg;

    localparam logic [2:0] FP_OP_NONE   = 3'd0;
    localparam logic [2:0] FP_OP_LOAD   = 3'd1;
    localparam logic [2:0] FP_OP_STORE  = 3'd2;
    localparam logic [2:0] FP_OP_FMADD  = 3'd3;
    localparam logic [2:0] FP_OP_FMSUB  = 3'd4;
    localparam logic [2:0] FP_OP_FNMSUB = 3'd5;
    localparam logic [2:0] FP_OP_FNMADD = 3'd6;
    localparam logic [2:0] FP_OP_OPFP   = 3'd7;

    localparam logic [4:0] FP_INSTR_FADD      = 5'd0;
    localparam logic [4:0] FP_INSTR_FSUB      = 5'd1;
    localparam logic [4:0] FP_INSTR_FMUL      = 5'd2;
    localparam logic [4:0] FP_INSTR_FDIV      = 5'd3;
    localparam logic [4:0] FP_INSTR_FSQRT     = 5'd4;
    localparam logic [4:0] FP_INSTR_FSGNJ     = 5'd5;
    localparam logic [4:0] FP_INSTR_FSGNJN    = 5'd6;
    localparam logic [4:0] FP_INSTR_FSGNJX    = 5'd7;
    localparam logic [4:0] FP_INSTR_FMIN      = 5'd8;
    localparam logic [4:0] FP_INSTR_FMAX      = 5'd9;
    localparam logic [4:0] FP_INSTR_FCVT_W_S  = 5'd10;
    localparam logic [4:0] FP_INSTR_FCVT_WU_S = 5'd11;
    localparam logic [4:0] FP_INSTR_FMV_X_W   = 5'd12;
    localparam logic [4:0] FP_INSTR_FEQ       = 5'd13;
    localparam logic [4:0] FP_INSTR_FLT       = 5'd14;
    localparam logic [4:0] FP_INSTR_FLE       = 5'd15;
    localparam logic [4:0] FP_INSTR_FCLASS    = 5'd16;
    localparam logic [4:0] FP_INSTR_FCVT_S_W  = 5'd17;
    localparam logic [4:0] FP_INSTR_FCVT_S_WU = 5'd18;
    localparam logic [4:0] FP_INSTR_FMV_W_X   = 5'd19;

    typedef struct packed {
        logic [2:0]  fp_op;
        logic [4:0]  func;
        logic [1:0]  fmt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [4:0]  rd;
        logic [11:0] offset;
        logic [2:0]  rm;
        logic        fp_read;
        logic        fp_write;
        logic        int_read;
        logic        int_write;
        logic        mem_read;
        logic        mem_write;
    } fp_dec_t;

    // Bit 0 = rs1, bit 1 = rs2, bit 2 = rs3 read from the FP register file.
    function automatic logic [2:0] fp_src_mask(input fp_dec_t pkt);
        logic [2:0] mask;
        mask = '0;
        case (pkt.fp_op)
            FP_OP_FMADD, FP_OP_FMSUB, FP_OP_FNMSUB, FP_OP_FNMADD: mask = 3'b111;
            FP_OP_STORE: mask = 3'b010;
            FP_OP_OPFP: begin
                mask[0] = !pkt.int_read;
                case (pkt.func)
                    FP_INSTR_FADD, FP_INSTR_FSUB, FP_INSTR_FMUL, FP_INSTR_FDIV,
                    FP_INSTR_FSGNJ, FP_INSTR_FSGNJN, FP_INSTR_FSGNJX,
                    FP_INSTR_FMIN, FP_INSTR_FMAX,
                    FP_INSTR_FEQ, FP_INSTR_FLT, FP_INSTR_FLE: mask[1] = 1'b1;
                    default: mask[1] = 1'b0;
                endcase
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Busy bit per FP register plus a count of in-flight FP-writing ops.
// Set wins over clear on the same register; flush overrides everything.
module fp_scoreboard #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [4:0]       set_rd,
    input  logic             clr_en,
    input  logic [4:0]       clr_rd,
    input  logic             flush,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] inflight
);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             clr_ok;

    always_comb begin
        // Stray writebacks (register not pending) are dropped so the count never underflows.
        clr_ok     = clr_en && busy_q[clr_rd] && (inflight_q != '0);
        busy_d     = busy_q;
        inflight_d = inflight_q;
        if (clr_ok) begin
            busy_d[clr_rd] = 1'b0;
            inflight_d     = inflight_d - CNT_W'(1);
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
            inflight_d     = inflight_d + CNT_W'(1);
        end
        if (flush) begin
            busy_d     = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
        end
    end

    assign busy     = busy_q;
    assign inflight = inflight_q;

`ifndef SYNTHESIS
    wb_on_idle_reg: assert property (@(posedge clk) disable iff (!rst_n)
        (clr_en && !flush) |-> busy_q[clr_rd])
        else $error("writeback to FP register that is not pending");
`endif

endmodule

// File: rtl/fp_issue_scoreboard.sv
// FP issue stage: holds one decoded packet and releases it once no RAW/WAW hazard
// or in-flight limit blocks it.
module fp_issue_scoreboard
    import fp_types_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned STALL_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  fp_dec_t            dec_pkt,
    output logic               iss_valid,
    input  logic               iss_ready,
    output fp_dec_t            iss_pkt,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    output logic [31:0]        busy_fp,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {StEmpty, StHold} state_e;

    state_e             state_q, state_d;
    fp_dec_t            pkt_q, pkt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               rdy_q;
    logic [CNT_W-1:0]   inflight;
    logic [2:0]         src_mask;
    logic               src_haz, hazard, issue, accept, hold;

    always_comb begin
        src_mask = fp_src_mask(pkt_q);
        src_haz  = (src_mask[0] && busy_fp[pkt_q.rs1]) ||
                   (src_mask[1] && busy_fp[pkt_q.rs2]) ||
                   (src_mask[2] && busy_fp[pkt_q.rs3]);
        hazard   = src_haz || (pkt_q.fp_write &&
                   (busy_fp[pkt_q.rd] || (inflight == CNT_W'(MAX_INFLIGHT))));
    end

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        stall_d   = stall_q;
        hold      = (state_q == StHold);
        iss_valid = hold && !hazard && !flush;
        issue     = iss_valid && iss_ready;
        // rdy_q keeps dec_ready low through reset and the first edge after release.
        dec_ready = rdy_q && !flush && (!hold || issue);
        accept    = dec_valid && dec_ready;

        if (accept) begin
            state_d = StHold;
            pkt_d   = dec_pkt;
        end else if (issue) begin
            state_d = StEmpty;
        end
        if (flush) begin
            state_d = StEmpty;
        end

        if (hold && hazard && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            pkt_q   <= '0;
            stall_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
            rdy_q   <= 1'b1;
        end
    end

    fp_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && pkt_q.fp_write),
        .set_rd   (pkt_q.rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .flush    (flush),
        .busy     (busy_fp),
        .inflight (inflight)
    );

    assign iss_pkt      = pkt_q;
    assign stall_cycles = stall_q;

endmodule
